// File: rtl/alu_mdu.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider, one bit per cycle.
// Optional divide engine is included only when MDU_DIV_EN is defined.
module alu_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_mdu_sel,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result_mdu,
    output logic            o_div_zero
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN-1:0]   opnd;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt;

    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   nxt_hi, nxt_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   mul_res, fin_res;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        if (i_mdu_sel[2]) begin
            a_sgn = ~i_mdu_sel[0];
            b_sgn = ~i_mdu_sel[0];
        end else begin
            a_sgn = (i_mdu_sel == 3'b001) || (i_mdu_sel == 3'b010);
            b_sgn = (i_mdu_sel == 3'b001);
        end
    end

    assign a_neg = a_sgn & i_rs1_data[XLEN-1];
    assign b_neg = b_sgn & i_rs2_data[XLEN-1];
    assign a_mag = a_neg ? -i_rs1_data : i_rs1_data;
    assign b_mag = b_neg ? -i_rs2_data : i_rs2_data;

    // Multiply: acc_lo holds the multiplier and fills with product bits from the top.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    assign prod    = {nxt_hi, nxt_lo};
    assign prod_s  = neg_q ? -prod : prod;
    assign mul_res = (op_q == 3'b000) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

`ifdef MDU_DIV_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic            neg_r;
    logic [XLEN:0]   div_shift, div_diff;
    logic [XLEN-1:0] div_hi, div_lo, quo_s, rem_s;

    // Divide: acc_hi is the partial remainder, acc_lo shifts the dividend out and quotient in.
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_hi    = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    assign div_lo    = {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
    assign nxt_hi    = op_q[2] ? div_hi : mul_sum[XLEN:1];
    assign nxt_lo    = op_q[2] ? div_lo : {mul_sum[0], acc_lo[XLEN-1:1]};
    assign quo_s     = neg_q ? -nxt_lo : nxt_lo;
    assign rem_s     = neg_r ? -nxt_hi : nxt_hi;
    assign fin_res   = op_q[2] ? (op_q[1] ? rem_s : quo_s) : mul_res;
`else
    assign nxt_hi  = mul_sum[XLEN:1];
    assign nxt_lo  = {mul_sum[0], acc_lo[XLEN-1:1]};
    assign fin_res = mul_res;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_ready      <= 1'b1;
            o_valid      <= 1'b0;
            o_result_mdu <= '0;
            o_div_zero   <= 1'b0;
            op_q         <= '0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            opnd         <= '0;
            neg_q        <= 1'b0;
            cnt          <= '0;
`ifdef MDU_DIV_EN
            neg_r        <= 1'b0;
`endif
        end else if (i_flush) begin
            state        <= IDLE;
            o_ready      <= 1'b1;
            o_valid      <= 1'b0;
            o_result_mdu <= '0;
            o_div_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        op_q    <= i_mdu_sel;
                        o_ready <= 1'b0;
                        if (i_mdu_sel[2]) begin
`ifdef MDU_DIV_EN
                            if (i_rs2_data == '0) begin
                                state        <= DONE;
                                o_valid      <= 1'b1;
                                o_result_mdu <= i_mdu_sel[1] ? i_rs1_data : '1;
                                o_div_zero   <= 1'b1;
                            end else if (!i_mdu_sel[0] && i_rs1_data == INT_MIN && i_rs2_data == '1) begin
                                state        <= DONE;
                                o_valid      <= 1'b1;
                                o_result_mdu <= i_mdu_sel[1] ? '0 : i_rs1_data;
                            end else begin
                                state  <= BUSY;
                                acc_hi <= '0;
                                acc_lo <= a_mag;
                                opnd   <= b_mag;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                cnt    <= CNT_W'(XLEN);
                            end
`else
                            state   <= DONE;
                            o_valid <= 1'b1;
`endif
                        end else begin
                            state  <= BUSY;
                            acc_hi <= '0;
                            acc_lo <= b_mag;
                            opnd   <= a_mag;
                            neg_q  <= a_neg ^ b_neg;
                            cnt    <= CNT_W'(XLEN);
                        end
                    end
                end
                BUSY: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state        <= DONE;
                        o_valid      <= 1'b1;
                        o_result_mdu <= fin_res;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state        <= IDLE;
                        o_ready      <= 1'b1;
                        o_valid      <= 1'b0;
                        o_result_mdu <= '0;
                        o_div_zero   <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at XLEN=32; divide expectations follow the MDU_DIV_EN build option.
`timescale 1ns/1ps

module tb_alu_mdu;
   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [2:0]  i_mdu_sel;
   logic [31:0] i_rs1_data;
   logic [31:0] i_rs2_data;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_result_mdu;
   logic        o_div_zero;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] res;
   logic        dz;
   int          edges;
   logic        seen;

   alu_mdu #(.XLEN(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_mdu_sel(i_mdu_sel), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
      .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
      .o_result_mdu(o_result_mdu), .o_div_zero(o_div_zero)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
      @(negedge i_clk);
      i_valid = 1'b1; i_mdu_sel = sel; i_rs1_data = a; i_rs2_data = b;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_mdu_sel = 3'($urandom_range(0, 7));
      i_rs1_data = $urandom; i_rs2_data = $urandom;
   endtask

   task automatic wait_done(output logic [31:0] r, output logic z, output int e);
      e = 1;
      while (o_valid !== 1'b1 && e < 100) begin
         @(posedge i_clk); #1;
         e++;
      end
      r = o_result_mdu;
      z = o_div_zero;
   endtask

   task automatic ack();
      @(negedge i_clk);
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output int e);
      issue(sel, a, b);
      wait_done(r, z, e);
      ack();
   endtask

   initial begin
      i_rst_n = 1'b0; i_valid = 1'b0; i_mdu_sel = '0; i_rs1_data = '0;
      i_rs2_data = '0; i_flush = 1'b0; i_ready = 1'b0;
      #12;
      n_cmp++; if (o_ready !== 1'b1) fail("rst_ready", o_ready, 1);
      n_cmp++; if (o_valid !== 1'b0) fail("rst_valid", o_valid, 0);
      n_cmp++; if (o_result_mdu !== 32'h0) fail("rst_result", o_result_mdu, 0);
      n_cmp++; if (o_div_zero !== 1'b0) fail("rst_dz", o_div_zero, 0);
      @(negedge i_clk); i_rst_n = 1'b1;

      run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, res, dz, edges);
      n_cmp++; if (edges != 33) fail("mul_edges", edges, 33);
      n_cmp++; if (res !== 32'hFFFF_FFFE) fail("mul_res", res, 32'hFFFF_FFFE);
      n_cmp++; if (dz !== 1'b0) fail("mul_dz", dz, 0);
      n_cmp++; if (o_valid !== 1'b0) fail("ack_valid", o_valid, 0);
      n_cmp++; if (o_result_mdu !== 32'h0) fail("ack_result", o_result_mdu, 0);
      n_cmp++; if (o_ready !== 1'b1) fail("ack_ready", o_ready, 1);

      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, res, dz, edges);
      n_cmp++; if (res !== 32'h4000_0000) fail("mulh_res", res, 32'h4000_0000);
      run_op(3'b011, 32'h8000_0000, 32'h8000_0000, res, dz, edges);
      n_cmp++; if (res !== 32'h4000_0000) fail("mulhu_res", res, 32'h4000_0000);
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, dz, edges);
      n_cmp++; if (res !== 32'hFFFF_FFFF) fail("mulhsu_res", res, 32'hFFFF_FFFF);
      n_cmp++; if (edges != 33) fail("mulhsu_edges", edges, 33);
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, dz, edges);
      n_cmp++; if (res !== 32'hFFFF_FFFE) fail("mulhu_max", res, 32'hFFFF_FFFE);
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, dz, edges);
      n_cmp++; if (res !== 32'h0000_0000) fail("mulh_m1", res, 32'h0);
      run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, res, dz, edges);
      n_cmp++; if (res !== 32'hFFFF_FFFF) fail("mulh_neg", res, 32'hFFFF_FFFF);

`ifdef MDU_DIV_EN
      run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, res, dz, edges);
      n_cmp++; if (res !== 32'hFFFF_FFFD) fail("div_res", res, 32'hFFFF_FFFD);
      n_cmp++; if (edges != 33) fail("div_edges", edges, 33);
      run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, res, dz, edges);
      n_cmp++; if (res !== 32'hFFFF_FFFF) fail("rem_res", res, 32'hFFFF_FFFF);
      run_op(3'b100, 32'h0000_0007, 32'hFFFF_FFFE, res, dz, edges);
      n_cmp++; if (res !== 32'hFFFF_FFFD) fail("div_negb", res, 32'hFFFF_FFFD);
      run_op(3'b110, 32'h0000_0007, 32'hFFFF_FFFE, res, dz, edges);
      n_cmp++; if (res !== 32'h0000_0001) fail("rem_negb", res, 32'h1);
      run_op(3'b101, 32'd100, 32'd7, res, dz, edges);
      n_cmp++; if (res !== 32'd14) fail("divu_res", res, 14);
      run_op(3'b111, 32'd100, 32'd7, res, dz, edges);
      n_cmp++; if (res !== 32'd2) fail("remu_res", res, 2);
      run_op(3'b101, 32'd7, 32'd0, res, dz, edges);
      n_cmp++; if (res !== 32'hFFFF_FFFF) fail("divu0_res", res, 32'hFFFF_FFFF);
      n_cmp++; if (dz !== 1'b1) fail("divu0_dz", dz, 1);
      n_cmp++; if (edges != 1) fail("divu0_edges", edges, 1);
      run_op(3'b110, 32'hFFFF_FFF9, 32'd0, res, dz, edges);
      n_cmp++; if (res !== 32'hFFFF_FFF9) fail("rem0_res", res, 32'hFFFF_FFF9);
      n_cmp++; if (dz !== 1'b1) fail("rem0_dz", dz, 1);
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, res, dz, edges);
      n_cmp++; if (res !== 32'h8000_0000) fail("ovf_div_res", res, 32'h8000_0000);
      n_cmp++; if (edges != 1) fail("ovf_div_edges", edges, 1);
      n_cmp++; if (dz !== 1'b0) fail("ovf_div_dz", dz, 0);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, res, dz, edges);
      n_cmp++; if (res !== 32'h0) fail("ovf_rem_res", res, 0);
`else
      run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, res, dz, edges);
      n_cmp++; if (res !== 32'h0) fail("nodiv_res", res, 0);
      n_cmp++; if (edges != 1) fail("nodiv_edges", edges, 1);
      run_op(3'b101, 32'd7, 32'd0, res, dz, edges);
      n_cmp++; if (res !== 32'h0) fail("nodiv0_res", res, 0);
      n_cmp++; if (dz !== 1'b0) fail("nodiv0_dz", dz, 0);
      n_cmp++; if (edges != 1) fail("nodiv0_edges", edges, 1);
`endif

      issue(3'b000, 32'h1234_5678, 32'h0000_0009);
      wait_done(res, dz, edges);
      n_cmp++; if (res !== 32'hA3D7_0A38) fail("hold_first", res, 32'hA3D7_0A38);
      for (int i = 0; i < 5; i++) begin
         @(posedge i_clk); #1;
         n_cmp++; if (o_valid !== 1'b1) fail("hold_valid", o_valid, 1);
         n_cmp++; if (o_result_mdu !== 32'hA3D7_0A38) fail("hold_res", o_result_mdu, 32'hA3D7_0A38);
      end

      @(negedge i_clk);
      i_ready = 1'b1; i_valid = 1'b1; i_mdu_sel = 3'b000;
      i_rs1_data = 32'd6; i_rs2_data = 32'd7;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      n_cmp++; if (o_ready !== 1'b1) fail("no_bypass_ready", o_ready, 1);
      n_cmp++; if (o_valid !== 1'b0) fail("no_bypass_valid", o_valid, 0);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      n_cmp++; if (o_ready !== 1'b0) fail("accept_next", o_ready, 0);
      wait_done(res, dz, edges);
      n_cmp++; if (res !== 32'd42) fail("b2b_res", res, 42);
      n_cmp++; if (edges != 33) fail("b2b_edges", edges, 33);
      ack();

      @(negedge i_clk);
      i_valid = 1'b1; i_flush = 1'b1; i_mdu_sel = 3'b000;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_flush = 1'b0;
      n_cmp++; if (o_ready !== 1'b1) fail("flush_vs_accept", o_ready, 1);

      issue(3'b000, 32'd3, 32'd5);
      repeat (9) @(posedge i_clk);
      @(negedge i_clk); i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      n_cmp++; if (o_ready !== 1'b1) fail("flush_ready", o_ready, 1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge i_clk); #1;
         if (o_valid === 1'b1) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) fail("flush_no_valid", seen, 0);

      issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (5) @(posedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      n_cmp++; if (o_ready !== 1'b1) fail("arst_ready", o_ready, 1);
      n_cmp++; if (o_valid !== 1'b0) fail("arst_valid", o_valid, 0);
      n_cmp++; if (o_result_mdu !== 32'h0) fail("arst_result", o_result_mdu, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1; i_valid = 1'b1; i_mdu_sel = 3'b011;
      i_rs1_data = 32'hFFFF_FFFF; i_rs2_data = 32'hFFFF_FFFF;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      n_cmp++; if (o_ready !== 1'b0) fail("post_rst_accept", o_ready, 0);
      wait_done(res, dz, edges);
      n_cmp++; if (res !== 32'hFFFF_FFFE) fail("post_rst_res", res, 32'hFFFF_FFFE);
      n_cmp++; if (edges != 33) fail("post_rst_edges", edges, 33);
      ack();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
